monster_sprite_fetch: RTL and testbench

Read-side engine for the monster sprite memory. Each cycle it takes the VGA draw coordinate, decides whether it falls inside the monster's 16x16 box, drives the sprite RAM read address, and, after the RAM's one-cycle read latency, presents the pixel colour with a transparency-qualified `sprite_on` flag to the colour mapper. It also latches the monster's position once per video frame and steps a two-frame walk animation.

---
 rtl/monster_sprite_pkg.sv | 13 +
 rtl/monster_anim_ctr.sv | 34 +++
 rtl/monster_sprite_fetch.sv | 125 ++++++++++++
 tb/tb_monster_sprite_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/monster_sprite_pkg.sv
// Shared constants and types for the monster sprite read engine.
package monster_sprite_pkg;

  localparam int unsigned SPRITE_W = 16;
  localparam int unsigned SPRITE_H = 16;
  localparam int unsigned FRAMES   = 2;

  typedef logic [23:0] rgb_t;
  typedef logic [8:0]  sprite_addr_t;

  localparam rgb_t TRANSPARENT = 24'hFF00FF;

endpackage

// File: rtl/monster_anim_ctr.sv
// Walk animation step counter: counts video frames and advances the
// animation frame index every ANIM_PERIOD frame_sync pulses.
module monster_anim_ctr
  import monster_sprite_pkg::*;
#(
  parameter int unsigned FRAMES      = monster_sprite_pkg::FRAMES,
  parameter int unsigned ANIM_PERIOD = 8,
  localparam int unsigned FrameW     = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int unsigned CntW       = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_sync,
  output logic [FrameW-1:0] anim_frame
);

  logic [CntW-1:0] vid_cnt;

  // Step vid_cnt per frame; on wrap advance anim_frame modulo FRAMES.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vid_cnt    <= '0;
      anim_frame <= '0;
    end else if (frame_sync) begin
      if (vid_cnt == CntW'(ANIM_PERIOD - 1)) begin
        vid_cnt    <= '0;
        anim_frame <= (anim_frame == FrameW'(FRAMES - 1)) ? '0 : anim_frame + FrameW'(1);
      end else begin
        vid_cnt <= vid_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/monster_sprite_fetch.sv
// Monster sprite read engine: box hit test, sprite RAM addressing and a
// transparency-qualified output stage, 3-cycle fixed latency.
// Optional feature: define MONSTER_FLIP_EN to mirror columns when the
// latched facing_left is high; otherwise facing_left is ignored.
module monster_sprite_fetch
  import monster_sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W    = monster_sprite_pkg::SPRITE_W,
  parameter int unsigned SPRITE_H    = monster_sprite_pkg::SPRITE_H,
  parameter int unsigned FRAMES      = monster_sprite_pkg::FRAMES,
  parameter int unsigned ANIM_PERIOD = 8,
  parameter rgb_t        TRANSPARENT = monster_sprite_pkg::TRANSPARENT
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_sync,
  input  logic         pixel_valid,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic [9:0]   MonsterX,
  input  logic [9:0]   MonsterY,
  input  logic         monster_alive,
  input  logic         facing_left,
  output sprite_addr_t read_address,
  input  rgb_t         ram_data,
  output logic         sprite_on,
  output rgb_t         sprite_rgb
);

  localparam int unsigned ColW   = $clog2(SPRITE_W);
  localparam int unsigned RowW   = $clog2(SPRITE_H);
  localparam int unsigned FrameW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  logic [9:0]        x_l, y_l;
  logic              alive_l;
  logic [FrameW-1:0] anim_frame;
  logic              hit, hit_d1, hit_d2;
  logic [ColW-1:0]   col_raw, col;
  logic [RowW-1:0]   row;
  sprite_addr_t      addr_next;

  monster_anim_ctr #(
    .FRAMES      (FRAMES),
    .ANIM_PERIOD (ANIM_PERIOD)
  ) u_anim_ctr (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_sync (frame_sync),
    .anim_frame (anim_frame)
  );

  // Capture the monster state once per frame so mid-frame changes are ignored.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_l     <= '0;
      y_l     <= '0;
      alive_l <= 1'b0;
    end else if (frame_sync) begin
      x_l     <= MonsterX;
      y_l     <= MonsterY;
      alive_l <= monster_alive;
    end
  end

`ifdef MONSTER_FLIP_EN
  logic flip_l;

  // Facing direction is latched alongside the position.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      flip_l <= 1'b0;
    end else if (frame_sync) begin
      flip_l <= facing_left;
    end
  end

  // Mirroring a power-of-two width is a bitwise invert of the column.
  assign col = flip_l ? ~col_raw : col_raw;
`else
  logic unused_facing_left;
  assign unused_facing_left = facing_left;
  assign col = col_raw;
`endif

  // 11-bit compares so a box near the right edge clips instead of wrapping.
  always_comb begin
    hit = pixel_valid & alive_l &
          ({1'b0, DrawX} >= {1'b0, x_l}) &
          ({1'b0, DrawX} <  ({1'b0, x_l} + 11'(SPRITE_W))) &
          ({1'b0, DrawY} >= {1'b0, y_l}) &
          ({1'b0, DrawY} <  ({1'b0, y_l} + 11'(SPRITE_H)));
    col_raw   = ColW'(DrawX - x_l);
    row       = RowW'(DrawY - y_l);
    addr_next = sprite_addr_t'(anim_frame) * sprite_addr_t'(SPRITE_W * SPRITE_H) +
                sprite_addr_t'(row) * sprite_addr_t'(SPRITE_W) +
                sprite_addr_t'(col);
  end

  // Address and hit pipeline; address holds on a miss.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      hit_d1       <= 1'b0;
      hit_d2       <= 1'b0;
    end else begin
      if (hit) begin
        read_address <= addr_next;
      end
      hit_d1 <= hit;
      hit_d2 <= hit_d1;
    end
  end

  // Output stage gates the RAM word with the delayed hit and colour key.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sprite_on  <= 1'b0;
      sprite_rgb <= '0;
    end else begin
      sprite_on  <= hit_d2 & (ram_data != TRANSPARENT);
      sprite_rgb <= (hit_d2 & (ram_data != TRANSPARENT)) ? ram_data : '0;
    end
  end

endmodule

// File: tb/tb_monster_sprite_fetch.sv
// Self-checking bench for monster_sprite_fetch with a registered sprite RAM.
module tb_monster_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset, frame_sync, pixel_valid, monster_alive, facing_left;
  logic [9:0]  DrawX, DrawY, MonsterX, MonsterY;
  logic [8:0]  read_address;
  logic [23:0] ram_data;
  logic        sprite_on;
  logic [23:0] sprite_rgb;

  logic [23:0] mem [0:511];

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  monster_sprite_fetch dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_sync    (frame_sync),
    .pixel_valid   (pixel_valid),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .MonsterX      (MonsterX),
    .MonsterY      (MonsterY),
    .monster_alive (monster_alive),
    .facing_left   (facing_left),
    .read_address  (read_address),
    .ram_data      (ram_data),
    .sprite_on     (sprite_on),
    .sprite_rgb    (sprite_rgb)
  );

  // Sprite RAM with one-cycle registered read.
  always @(posedge Clk) ram_data <= mem[read_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame state, frame_sync count and a 4-slot schedule
  // of expected outputs two edges ahead of the sampling edge.
  int          k = 0;
  int          m_x, m_y, m_fs;
  bit          m_alive, m_flip;
  logic [8:0]  m_addr;
  bit          exp_on  [4];
  logic [23:0] exp_rgb [4];

  always @(posedge Clk) begin : model
    int dx, dy, col, row;
    bit h;
    k++;
    if (Reset) begin
      m_x = 0; m_y = 0; m_fs = 0; m_alive = 0; m_flip = 0; m_addr = '0;
      for (int i = 0; i < 4; i++) begin
        exp_on[i]  = 0;
        exp_rgb[i] = '0;
      end
    end else begin
      dx = int'(DrawX);
      dy = int'(DrawY);
      h  = pixel_valid && m_alive && dx >= m_x && dx < m_x + 16 && dy >= m_y && dy < m_y + 16;
      if (h) begin
        col = dx - m_x;
        row = dy - m_y;
`ifdef MONSTER_FLIP_EN
        if (m_flip) col = 15 - col;
`endif
        m_addr = 9'(((m_fs / 8) % 2) * 256 + row * 16 + col);
      end
      exp_on[(k + 2) % 4]  = h && (mem[m_addr] != 24'hFF00FF);
      exp_rgb[(k + 2) % 4] = (h && (mem[m_addr] != 24'hFF00FF)) ? mem[m_addr] : 24'h0;
      if (frame_sync) begin
        m_x     = int'(MonsterX);
        m_y     = int'(MonsterY);
        m_alive = monster_alive;
        m_flip  = facing_left;
        m_fs++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    chk("cyc_read_address", 32'(read_address), 32'(m_addr));
    chk("cyc_sprite_on", 32'(sprite_on), 32'(exp_on[k % 4]));
    chk("cyc_sprite_rgb", 32'(sprite_rgb), 32'(exp_rgb[k % 4]));
  end

  task automatic put(input bit fs, input bit pv, input int x, input int y);
    frame_sync  = fs;
    pixel_valid = pv;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    @(negedge Clk);
    #1;
  endtask

  // Draw one pixel, check the address next cycle and the output 3 cycles on.
  task automatic probe(input string name, input int x, input int y,
                       input logic [8:0] ea, input bit eon, input logic [23:0] ergb);
    put(0, 1, x, y);
    chk({name, "_addr"}, 32'(read_address), 32'(ea));
    put(0, 0, 0, 0);
    put(0, 0, 0, 0);
    chk({name, "_on"}, 32'(sprite_on), 32'(eon));
    chk({name, "_rgb"}, 32'(sprite_rgb), 32'(ergb));
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 24'h100000 | 24'(i * 257);
    mem[9'h036] = 24'hFF00FF;

    Reset = 1; frame_sync = 0; pixel_valid = 0; DrawX = '0; DrawY = '0;
    MonsterX = '0; MonsterY = '0; monster_alive = 0; facing_left = 0;
    @(negedge Clk); #1;
    chk("reset_addr", 32'(read_address), 32'h0);
    chk("reset_on", 32'(sprite_on), 32'h0);
    chk("reset_rgb", 32'(sprite_rgb), 32'h0);
    @(negedge Clk); #1;
    Reset = 0;

    // Nothing drawn before the first frame_sync.
    for (int i = 0; i < 4; i++) put(0, 1, 100, 100);
    put(0, 0, 0, 0); put(0, 0, 0, 0);
    chk("pre_sync_on", 32'(sprite_on), 32'h0);

    MonsterX = 10'd100; MonsterY = 10'd50; monster_alive = 1;
    put(1, 0, 0, 0);                                          // sync 1
    probe("p105_53", 105, 53, 9'h035, 1, 24'h103535);
    probe("p116_53", 116, 53, 9'h035, 0, 24'h0);
    probe("p99_53", 99, 53, 9'h035, 0, 24'h0);
    probe("p100_50", 100, 50, 9'h000, 1, 24'h100000);
    probe("p115_65", 115, 65, 9'h0FF, 1, 24'h10FFFF);
    probe("p100_66", 100, 66, 9'h0FF, 0, 24'h0);
    probe("transp", 106, 53, 9'h036, 0, 24'h0);

    for (int i = 0; i < 7; i++) put(1, 0, 0, 0);              // syncs 2..8
    probe("anim1", 105, 53, 9'h135, 1, 24'h113635);
    for (int i = 0; i < 8; i++) put(1, 0, 0, 0);              // syncs 9..16
    probe("anim0", 105, 53, 9'h035, 1, 24'h103535);

    MonsterX = 10'd1020;
    put(1, 0, 0, 0);                                          // sync 17
    probe("edge1023", 1023, 53, 9'h033, 1, 24'h103333);
    probe("nowrap3", 3, 53, 9'h033, 0, 24'h0);
    probe("left1019", 1019, 53, 9'h033, 0, 24'h0);

    MonsterX = 10'd100; facing_left = 1;
    put(1, 0, 0, 0);                                          // sync 18
    MonsterX = 10'd300;
`ifdef MONSTER_FLIP_EN
    probe("flip", 105, 53, 9'h03A, 1, 24'h103A3A);
`else
    probe("noflip", 105, 53, 9'h035, 1, 24'h103535);
`endif

    // Latch on a hit cycle: the pixel uses the old (alive) registers.
    monster_alive = 0;
    put(1, 1, 100, 50);                                       // sync 19
    put(0, 0, 0, 0); put(0, 0, 0, 0);
    chk("same_cycle_on", 32'(sprite_on), 32'h1);
    probe("dead", 105, 53, 9'h000, 0, 24'h0);

    // Mid-line reset flushes the pipeline.
    MonsterX = 10'd100; monster_alive = 1; facing_left = 0;
    put(1, 0, 0, 0);
    put(0, 1, 100, 50); put(0, 1, 101, 50); put(0, 1, 102, 50);
    Reset = 1;
    put(0, 1, 103, 50);
    chk("rst_flush_on", 32'(sprite_on), 32'h0);
    chk("rst_flush_addr", 32'(read_address), 32'h0);
    Reset = 0;
    for (int i = 0; i < 4; i++) put(0, 1, 104, 50);
    chk("post_rst_on", 32'(sprite_on), 32'h0);
    put(0, 0, 0, 0); put(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
